// File: rtl/esp_init_ctrl_if.sv
// Byte-stream UART link between the ESP8266 bring-up sequencer (master) and the UART (slave).
interface esp_init_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );
endinterface

// File: rtl/esp_init_ctrl.sv
// ESP8266 bring-up: reset pulse, boot wait, two-command AT script with "OK" check, full retry on timeout.
// Bytes are presented back-to-back while tx_ready is high; tx_data is held stable under backpressure.
module esp_init_ctrl #(
  parameter logic [31:0] BOOT_WAIT = 32'd1000,
  parameter logic [31:0] TIMEOUT   = 32'd5000,
  parameter logic [2:0]  MAX_RETRY = 3'd2
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            start,
  output logic            mod_rst_req,
  input  logic            mod_rst,
  esp_init_ctrl_if.master uart,
  output logic            busy,
  output logic            ready,
  output logic            error
);

  typedef enum logic [3:0] {
    IDLE, RST_REQ, RST_LOW, RST_HIGH, BOOT, SEND, WAIT_RSP, DONE, FAIL
  } state_t;

  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_K     = 8'h4B;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [3:0] LAST_IDX = 4'd9;

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [2:0]  retry, retry_nxt;
  logic        seen_o, seen_o_nxt;
  logic [31:0] timer, timer_nxt, timer_inc;
  logic        ready_nxt, error_nxt;
  logic [7:0]  tx_byte;
  logic        rsp_match;

  function automatic logic [7:0] rom(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h41;
      4'd1:    return 8'h54;
      4'd2:    return 8'h0D;
      4'd3:    return 8'h0A;
      4'd4:    return 8'h41;
      4'd5:    return 8'h54;
      4'd6:    return 8'h45;
      4'd7:    return 8'h30;
      4'd8:    return 8'h0D;
      4'd9:    return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state  <= IDLE;
      idx    <= '0;
      retry  <= '0;
      seen_o <= 1'b0;
      timer  <= '0;
      ready  <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      retry  <= retry_nxt;
      seen_o <= seen_o_nxt;
      timer  <= timer_nxt;
      ready  <= ready_nxt;
      error  <= error_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    retry_nxt  = retry;
    seen_o_nxt = seen_o;
    timer_nxt  = timer;
    ready_nxt  = ready;
    error_nxt  = error;
    timer_inc  = (timer == 32'hFFFF_FFFF) ? timer : timer + 32'd1;
    tx_byte    = rom(idx);
    rsp_match  = uart.rx_valid && (uart.rx_data == CH_K) && seen_o;

    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_nxt = RST_REQ;
          ready_nxt = 1'b0;
          error_nxt = 1'b0;
          retry_nxt = '0;
        end
      end
      RST_REQ: state_nxt = RST_LOW;
      RST_LOW: begin
        if (!mod_rst) state_nxt = RST_HIGH;
      end
      RST_HIGH: begin
        if (mod_rst) begin
          state_nxt = BOOT;
          timer_nxt = '0;
        end
      end
      BOOT: begin
        // BOOT lasts exactly BOOT_WAIT cycles, so compare the post-increment count
        if (timer_inc >= BOOT_WAIT) begin
          state_nxt = SEND;
          idx_nxt   = '0;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer_inc;
        end
      end
      SEND: begin
        if (uart.tx_ready) begin
          if (tx_byte == CH_LF) begin
            state_nxt  = WAIT_RSP;
            timer_nxt  = '0;
            seen_o_nxt = 1'b0;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      WAIT_RSP: begin
        timer_nxt = timer_inc;
        // idx still points at the command's LF; a match beats a same-cycle timeout
        if (rsp_match) begin
          seen_o_nxt = 1'b0;
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
            ready_nxt = 1'b1;
          end else begin
            state_nxt = SEND;
            idx_nxt   = idx + 4'd1;
          end
        end else begin
          if (uart.rx_valid) seen_o_nxt = (uart.rx_data == CH_O);
          if (timer_inc >= TIMEOUT) begin
            if (retry < MAX_RETRY) begin
              retry_nxt = retry + 3'd1;
              state_nxt = RST_REQ;
            end else begin
              state_nxt = FAIL;
              error_nxt = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mod_rst_req   = (state == RST_REQ);
  assign busy          = !((state == IDLE) || (state == DONE) || (state == FAIL));
  assign uart.tx_valid = (state == SEND);
  assign uart.tx_data  = (state == SEND) ? tx_byte : 8'h00;

endmodule
